load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 17 +
 rtl/store_buffer.sv | 73 +++++++
 rtl/load_store_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared widths and defaults for the load/store unit and its store buffer.
package lsu_pkg;

  localparam int unsigned LSU_DATA_W     = 16;
  localparam int unsigned LSU_IDX_W      = 8;
  localparam int unsigned LSU_RD_W       = 3;
  localparam int unsigned LSU_SB_DEPTH   = 2;
  localparam int unsigned LSU_STARVE_LIM = 4;

  // Owner of the shared memory port in a given cycle.
  typedef enum logic [1:0] {
    MemIdle,
    MemLoad,
    MemDrain
  } mem_op_e;

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer with an occupancy count and a youngest-entry lookup
// on the low address bits, used for load forwarding.
module store_buffer
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = LSU_DATA_W,
  parameter int unsigned DEPTH  = LSU_SB_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_push,
  input  logic [DATA_W-1:0]    i_push_addr,
  input  logic [DATA_W-1:0]    i_push_data,
  input  logic                 i_pop,
  output logic [DATA_W-1:0]    o_head_addr,
  output logic [DATA_W-1:0]    o_head_data,
  output logic                 o_full,
  output logic                 o_empty,
  input  logic [LSU_IDX_W-1:0] i_lookup_idx,
  output logic                 o_hit,
  output logic [DATA_W-1:0]    o_hit_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_idx;

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + 1'b1;
      if (i_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Payload storage carries no reset; validity comes from the count.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
  end

  // Walk oldest to youngest so the last valid match wins.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = r_head;
    for (int k = 0; k < int'(DEPTH); k++) begin
      w_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && (r_addr[w_idx][LSU_IDX_W-1:0] == i_lookup_idx)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: loads own the memory port in their cycle, buffered stores
// drain in any other cycle, and a starvation guard forces a drain when full.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W     = LSU_DATA_W,
  parameter int unsigned SB_DEPTH   = LSU_SB_DEPTH,
  parameter int unsigned STARVE_LIM = LSU_STARVE_LIM
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_st,
  input  logic [DATA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [LSU_RD_W-1:0] req_rd,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic [LSU_RD_W-1:0] resp_rd,
  output logic [DATA_W-1:0]   mem_access_addr,
  output logic [DATA_W-1:0]   mem_writ_data,
  output logic                mem_writ_en,
  input  logic [DATA_W-1:0]   mem_rea_data,
  output logic                sb_empty
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIM + 1);

  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [LSU_RD_W-1:0] r_resp_rd;
  logic [STARVE_W-1:0] r_starve;

  logic              w_full;
  logic              w_empty;
  logic              w_force;
  logic              w_st_acc;
  logic              w_ld_acc;
  logic              w_drain;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic [DATA_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [DATA_W-1:0] w_ld_data;
  mem_op_e           w_op;

  // Store readiness looks only at the start-of-cycle fill level.
  assign w_force   = (r_starve == STARVE_W'(STARVE_LIM));
  assign req_ready = req_is_st ? !w_full : !w_force;
  assign w_st_acc  = req_valid && req_is_st && req_ready;
  assign w_ld_acc  = req_valid && !req_is_st && req_ready;
  assign w_drain   = rst_n && !w_ld_acc && !w_empty;
  assign w_ld_data = w_hit ? w_hit_data : mem_rea_data;
  assign sb_empty  = w_empty;

  store_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (SB_DEPTH)
  ) u_store_buffer (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_push       (w_st_acc),
    .i_push_addr  (req_addr),
    .i_push_data  (req_wdata),
    .i_pop        (w_drain),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .i_lookup_idx (req_addr[LSU_IDX_W-1:0]),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );

  always_comb begin
    w_op = MemIdle;
    if (w_ld_acc)     w_op = MemLoad;
    else if (w_drain) w_op = MemDrain;
  end

  always_comb begin
    mem_access_addr = '0;
    mem_writ_data   = '0;
    mem_writ_en     = 1'b0;
    unique case (w_op)
      MemLoad: mem_access_addr = req_addr;
      MemDrain: begin
        mem_access_addr = w_head_addr;
        mem_writ_data   = w_head_data;
        mem_writ_en     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_starve     <= '0;
    end else begin
      r_resp_valid <= w_ld_acc;
      if (w_ld_acc) begin
        r_resp_data <= w_ld_data;
        r_resp_rd   <= req_rd;
      end
      if (w_force)                r_starve <= '0;
      else if (w_full && w_ld_acc) r_starve <= r_starve + 1'b1;
      else                        r_starve <= '0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;

endmodule
